// File: rtl/somador_serial_param.sv
// rtl/somador_serial_param.sv - multi-cycle sliced adder/subtractor with carry register between slices
module somador_serial_param #(
    parameter int LARGURA = 16,
    parameter int FATIA   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    input  logic               sub,
    input  logic [LARGURA-1:0] vet1,
    input  logic [LARGURA-1:0] vet2,
    input  logic               cin,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] vetr,
    output logic               cout,
    output logic               ovf
);

    localparam bit PARAM_OK = (FATIA >= 1) && (FATIA <= LARGURA)
                              && ((LARGURA % ((FATIA >= 1) ? FATIA : 1)) == 0);
    localparam int NFATIAS  = LARGURA / ((FATIA >= 1) ? FATIA : 1);
    localparam int IDX_W    = (NFATIAS > 1) ? $clog2(NFATIAS) : 1;
    localparam logic [IDX_W-1:0] ULTIMA = IDX_W'(NFATIAS - 1);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FIM    = 2'd2;

    if (!PARAM_OK) begin : g_param_invalido
        $error("somador_serial_param: FATIA must divide LARGURA and lie in 1..LARGURA");
    end

    logic [1:0]         estado;
    logic [LARGURA-1:0] reg_a;
    logic [LARGURA-1:0] reg_b;
    logic [LARGURA-1:0] acc;
    logic [LARGURA-1:0] acc_prox;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [FATIA-1:0]   fat_a;
    logic [FATIA-1:0]   fat_b;
    logic [FATIA:0]     soma;
    logic               c_msb;
    logic               ultima;

    // Carry into the slice MSB is recovered from the sum bit instead of a second adder chain.
    always_comb begin
        fat_a    = reg_a[int'(idx) * FATIA +: FATIA];
        fat_b    = reg_b[int'(idx) * FATIA +: FATIA];
        soma     = {1'b0, fat_a} + {1'b0, fat_b} + {{FATIA{1'b0}}, carry};
        c_msb    = soma[FATIA-1] ^ fat_a[FATIA-1] ^ fat_b[FATIA-1];
        acc_prox = acc;
        acc_prox[int'(idx) * FATIA +: FATIA] = soma[FATIA-1:0];
        ultima   = (idx == ULTIMA);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado  <= OCIOSO;
            reg_a   <= '0;
            reg_b   <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
            vetr    <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO, FIM: begin
                    if (inicio) begin
                        // Subtraction is folded into an add of ~B with inverted borrow.
                        reg_a   <= vet1;
                        reg_b   <= vet2 ^ {LARGURA{sub}};
                        carry   <= cin ^ sub;
                        idx     <= '0;
                        ocupado <= 1'b1;
                        estado  <= CALC;
                    end else begin
                        estado <= OCIOSO;
                    end
                end
                CALC: begin
                    acc   <= acc_prox;
                    carry <= soma[FATIA];
                    if (ultima) begin
                        vetr    <= acc_prox;
                        cout    <= soma[FATIA];
                        ovf     <= soma[FATIA] ^ c_msb;
                        pronto  <= 1'b1;
                        ocupado <= 1'b0;
                        idx     <= '0;
                        estado  <= FIM;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_somador_serial_param.sv
// tb/tb_somador_serial_param.sv - randomized model-checked bench over FATIA = 4, 16 and 1
module tb_somador_serial_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_g  = 0;
    bit done [3];

    always @(posedge clk) cyc_g <= cyc_g + 1;

    // Reference: {ovf, cout, vetr} from plain integer arithmetic on 16-bit operands.
    function automatic logic [17:0] model_calc(input logic [15:0] a, input logic [15:0] b,
                                               input logic s, input logic c);
        longint ua, ub, cl, us, sa, sb, ss;
        logic [63:0] ubits;
        logic        co, ov;
        ua = longint'(a);
        ub = longint'(b);
        cl = longint'(c);
        if (s) us = ua - ub - cl + 65536;
        else   us = ua + ub + cl;
        co = (us >= 65536);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        ss = s ? (sa - sb - cl) : (sa + sb + cl);
        ov = (ss > 32767) || (ss < -32768);
        ubits = 64'(us);
        return {ov, co, ubits[15:0]};
    endfunction

    task automatic check_lit(input string name, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ovf/cout/vetr=%h required %h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int F  = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
        localparam int NF = 16 / F;

        logic        rst_n, inicio, sub, cin;
        logic [15:0] vet1, vet2;
        logic        ocupado, pronto, cout, ovf;
        logic [15:0] vetr;

        int          m_left   = 0;
        logic        m_pronto = 1'b0;
        logic [17:0] m_res    = '0;
        logic [17:0] p_res    = '0;
        bit          chk_en   = 1'b0;

        somador_serial_param #(.LARGURA(16), .FATIA(F)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .inicio  (inicio),
            .sub     (sub),
            .vet1    (vet1),
            .vet2    (vet2),
            .cin     (cin),
            .ocupado (ocupado),
            .pronto  (pronto),
            .vetr    (vetr),
            .cout    (cout),
            .ovf     (ovf)
        );

        // Timeline model: an accepted start makes the result visible NF edges later.
        always @(posedge clk) begin
            if (!rst_n) begin
                m_left   <= 0;
                m_pronto <= 1'b0;
                m_res    <= '0;
            end else begin
                m_pronto <= (m_left == 1);
                if (m_left == 1) m_res <= p_res;
                if (m_left > 0) m_left <= m_left - 1;
                else if (inicio) begin
                    m_left <= NF;
                    p_res  <= model_calc(vet1, vet2, sub, cin);
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    checks++;
                    if ({ocupado, pronto, ovf, cout, vetr} !== {m_left > 0, m_pronto, m_res}) begin
                        errors++;
                        $display("FAIL cycle F=%0d t=%0t: ocupado=%b pronto=%b ovf=%b cout=%b vetr=%h required ocupado=%b pronto=%b ovf=%b cout=%b vetr=%h",
                                 F, $time, ocupado, pronto, ovf, cout, vetr,
                                 m_left > 0, m_pronto, m_res[17], m_res[16], m_res[15:0]);
                    end
                end
            end
        end

        task automatic idle(input int n);
            repeat (n) @(negedge clk);
        endtask

        task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                              input logic c, input bit noise, output int t_pronto);
            int cyc;
            vet1   = a;
            vet2   = b;
            sub    = s;
            cin    = c;
            inicio = 1'b1;
            @(negedge clk);
            inicio = noise;
            vet1   = 16'($urandom);
            vet2   = 16'($urandom);
            sub    = 1'($urandom);
            cin    = 1'($urandom);
            cyc    = 0;
            while (pronto !== 1'b1 && cyc < 64) begin
                @(negedge clk);
                inicio = 1'b0;
                cyc++;
            end
            inicio = 1'b0;
            checks++;
            if (cyc != NF) begin
                errors++;
                $display("FAIL latency F=%0d: got %0d cycles required %0d", F, cyc, NF);
            end
            t_pronto = cyc_g;
        endtask

        initial begin
            int t1, t2;
            rst_n  = 1'b0;
            inicio = 1'b1;
            sub    = 1'b0;
            cin    = 1'b1;
            vet1   = 16'hA5A5;
            vet2   = 16'h5A5A;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk_en = 1'b1;
            checks++;
            if ({ocupado, pronto, ovf, cout, vetr} !== 20'h0) begin
                errors++;
                $display("FAIL reset F=%0d: got ocupado=%b pronto=%b ovf=%b cout=%b vetr=%h required all 0",
                         F, ocupado, pronto, ovf, cout, vetr);
            end
            rst_n  = 1'b1;
            inicio = 1'b0;
            idle(2);

            run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, t1);
            idle(1);
            run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, t1);
            run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, t1);
            idle(2);
            run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, t1);
            idle(1);
            run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, t1);
            idle(1);

            run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, t1);
            run_op(16'h1111, 16'h2222, 1'b1, 1'b1, 1'b0, t2);
            checks++;
            if (t2 - t1 != NF + 1) begin
                errors++;
                $display("FAIL back_to_back F=%0d: got spacing %0d required %0d", F, t2 - t1, NF + 1);
            end
            idle(2);

            vet1   = 16'h4444;
            vet2   = 16'h3333;
            sub    = 1'b0;
            cin    = 1'b0;
            inicio = 1'b1;
            @(negedge clk);
            inicio = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            checks++;
            if ({ocupado, pronto, ovf, cout, vetr} !== 20'h0) begin
                errors++;
                $display("FAIL reset_abort F=%0d: got ocupado=%b pronto=%b ovf=%b cout=%b vetr=%h required all 0",
                         F, ocupado, pronto, ovf, cout, vetr);
            end
            idle(NF + 2);
            run_op(16'hBEEF, 16'h1234, 1'b0, 1'b1, 1'b0, t1);
            idle(1);

            for (int i = 0; i < 30; i++) begin
                run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), t1);
                if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
            end
            idle(3);
            done[g] = 1'b1;
        end
    end

    initial begin
        check_lit("model_add_5555", model_calc(16'h1234, 16'h4321, 1'b0, 1'b0), {1'b0, 1'b0, 16'h5555});
        check_lit("model_ripple",   model_calc(16'hFFFF, 16'h0000, 1'b0, 1'b1), {1'b0, 1'b1, 16'h0000});
        check_lit("model_add_ovf",  model_calc(16'h7FFF, 16'h0001, 1'b0, 1'b0), {1'b1, 1'b0, 16'h8000});
        check_lit("model_sub_neg",  model_calc(16'h0005, 16'h0007, 1'b1, 1'b0), {1'b0, 1'b0, 16'hFFFE});
        check_lit("model_sub_ovf",  model_calc(16'h8000, 16'h0001, 1'b1, 1'b0), {1'b1, 1'b1, 16'h7FFF});
        for (int t = 0; t < 20000; t++) begin
            if (done[0] && done[1] && done[2]) break;
            @(posedge clk);
        end
        checks++;
        if (!(done[0] && done[1] && done[2])) begin
            errors++;
            $display("FAIL timeout: got done=%b%b%b required 111", done[2], done[1], done[0]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
